// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data memory (DM).
// Optional fetch fairness is enabled by defining ARB_FETCH_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_DM_GRANTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  bus_err,
    output logic                  stall,
    output logic [1:0]            state_dbg
);

    // Handshake: a requester holds its req until its valid pulses for one
    // cycle; the memory sees mem_req held stable until mem_ready pulses once.

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_DM = 2'd1;
    localparam logic [1:0] BUSY_IF = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             done_q;
    logic             flush_q;
    logic             flush_pending;
    logic             tmo_hit;
    logic             grant_dm;
    logic             grant_if;

    assign state_dbg     = state;
    assign flush_pending = (state == BUSY_IF) && (flush_q || !if_req);
    assign tmo_hit       = (state != IDLE) && !mem_ready && (tmo_cnt == TMO_LAST);
    assign stall         = (dm_req && !dm_valid) || (if_req && !if_valid && !flush_pending);

`ifdef ARB_FETCH_FAIRNESS_EN
    localparam int GCNT_W = (MAX_DM_GRANTS > 1) ? $clog2(MAX_DM_GRANTS + 1) : 1;
    localparam logic [GCNT_W-1:0] DM_MAX = GCNT_W'(MAX_DM_GRANTS);
    logic [GCNT_W-1:0] dm_cnt;

    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && !done_q) begin
            if (if_req && dm_cnt >= DM_MAX) grant_if = 1'b1;
            else if (dm_req)                grant_dm = 1'b1;
            else if (if_req)                grant_if = 1'b1;
        end
    end

    // Saturates at the limit so a long DM burst with no fetch pending cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_cnt <= '0;
        end else if (grant_if) begin
            dm_cnt <= '0;
        end else if (grant_dm && dm_cnt != DM_MAX) begin
            dm_cnt <= dm_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && !done_q) begin
            if (dm_req)      grant_dm = 1'b1;
            else if (if_req) grant_if = 1'b1;
        end
    end
`endif

    // done_q marks the IDLE cycle right after completion, when the finished
    // requester's req is still high and must not be granted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            done_q    <= 1'b0;
            flush_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            bus_err  <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wstrb <= dm_wstrb;
                        tmo_cnt   <= '0;
                        state     <= BUSY_DM;
                    end else if (grant_if) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wstrb <= {STRB_W{1'b0}};
                        tmo_cnt   <= '0;
                        flush_q   <= 1'b0;
                        state     <= BUSY_IF;
                    end
                end
                BUSY_DM: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        dm_rdata <= mem_rdata;
                        dm_valid <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        dm_valid <= 1'b1;
                        bus_err  <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                BUSY_IF: begin
                    // A flushed fetch still finishes on the bus but reports nothing.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!flush_pending) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                        flush_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        if_valid <= !flush_pending;
                        bus_err  <= !flush_pending;
                        flush_q  <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        flush_q <= flush_pending;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
